// File: rtl/combat_pkg.sv
// Shared types, codes and hit geometry for the combat round controller.
package combat_pkg;

    typedef enum logic [1:0] {
        COUNTDOWN = 2'd0,
        FIGHT     = 2'd1,
        KO        = 2'd2,
        OVER      = 2'd3
    } game_state_t;

    localparam logic [9:0] ACT_IDLE      = 10'd9;
    localparam logic [9:0] ACT_PUNCH_HIT = 10'd14;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;

    // Victim must sit in front of the attacker, within reach, at nearly the same height.
    function automatic logic hit_geom(
        input logic [9:0] ax,
        input logic [9:0] ay,
        input logic       face_right,
        input logic [9:0] vx,
        input logic [9:0] vy,
        input logic [9:0] reach,
        input logic [9:0] ytol
    );
        logic signed [10:0] dx;
        logic signed [10:0] rch;
        logic        [9:0]  dy;
        logic               ok;
        dx  = $signed({1'b0, vx}) - $signed({1'b0, ax});
        rch = $signed({1'b0, reach});
        dy  = (ay > vy) ? (ay - vy) : (vy - ay);
        if (face_right)
            ok = (dx > 11'sd0) && (dx <= rch);
        else
            ok = (dx < 11'sd0) && (dx >= -rch);
        return ok && (dy <= ytol);
    endfunction

    function automatic logic [7:0] sat_sub(
        input logic [7:0] h,
        input logic [7:0] d
    );
        return (h > d) ? (h - d) : 8'd0;
    endfunction

endpackage

// File: rtl/combat_ctrl_frame_tick.sv
// Frame clock edge detector: one-Clk tick two cycles after a frame_clk rise.
module frame_tick (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic sync;
    logic delay;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync  <= 1'b0;
            delay <= 1'b0;
            tick  <= 1'b0;
        end else begin
            sync  <= frame_clk;
            delay <= sync;
            tick  <= sync & ~delay;
        end
    end

endmodule

// File: rtl/combat_ctrl.sv
// Round sequencing, punch landing, health and invulnerability cooldown
// for a two-player fighting game.
module combat_ctrl
    import combat_pkg::*;
#(
    parameter logic [7:0] MAX_HEALTH   = 8'd100,
    parameter logic [7:0] DAMAGE       = 8'd10,
    parameter logic [9:0] REACH        = 10'd70,
    parameter logic [9:0] Y_TOL        = 10'd20,
    parameter logic [9:0] HIT_FRAME    = ACT_PUNCH_HIT,
    parameter logic [5:0] COOLDOWN     = 6'd16,
    parameter logic [7:0] START_FRAMES = 8'd120,
    parameter logic [7:0] KO_FRAMES    = 8'd90
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [9:0] p1x,
    input  logic [9:0] p1y,
    input  logic [9:0] p2x,
    input  logic [9:0] p2y,
    input  logic [9:0] action1,
    input  logic [9:0] action2,
    input  logic [9:0] direction1,
    input  logic [9:0] direction2,
    output logic [7:0] health1,
    output logic [7:0] health2,
    output logic       hit1,
    output logic       hit2,
    output logic [1:0] winner,
    output logic [1:0] game_state,
    output logic       fight_enable
);

    logic        tick;
    game_state_t state;
    game_state_t state_n;
    logic [7:0]  cnt;
    logic [7:0]  cnt_n;
    logic [7:0]  h1_n;
    logic [7:0]  h2_n;
    logic [5:0]  cd1;
    logic [5:0]  cd2;
    logic [5:0]  cd1_n;
    logic [5:0]  cd2_n;
    logic [1:0]  win_n;
    logic [9:0]  prev1;
    logic [9:0]  prev2;
    logic        strike1;
    logic        strike2;
    logic        land_on1;
    logic        land_on2;
    logic        unused_dir;

    frame_tick u_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    assign unused_dir = ^{direction1[9:1], direction2[9:1]};
    assign game_state = state;

    assign strike1 = (action1 == HIT_FRAME) && (prev1 != HIT_FRAME);
    assign strike2 = (action2 == HIT_FRAME) && (prev2 != HIT_FRAME);

    // land_on2: player 1 lands on player 2, and vice versa.
    assign land_on2 = strike1 && (state == FIGHT) && (cd2 == 6'd0) &&
                      hit_geom(p1x, p1y, direction1[0], p2x, p2y, REACH, Y_TOL);
    assign land_on1 = strike2 && (state == FIGHT) && (cd1 == 6'd0) &&
                      hit_geom(p2x, p2y, direction2[0], p1x, p1y, REACH, Y_TOL);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        win_n   = winner;
        h1_n    = health1;
        h2_n    = health2;
        cd1_n   = (cd1 != 6'd0) ? (cd1 - 6'd1) : cd1;
        cd2_n   = (cd2 != 6'd0) ? (cd2 - 6'd1) : cd2;
        if (land_on1) begin
            h1_n  = sat_sub(health1, DAMAGE);
            cd1_n = COOLDOWN;
        end
        if (land_on2) begin
            h2_n  = sat_sub(health2, DAMAGE);
            cd2_n = COOLDOWN;
        end
        unique case (state)
            COUNTDOWN: begin
                if (cnt == START_FRAMES - 8'd1) begin
                    state_n = FIGHT;
                    cnt_n   = 8'd0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            FIGHT: begin
                if (h1_n == 8'd0 || h2_n == 8'd0) begin
                    state_n = KO;
                    cnt_n   = 8'd0;
                    if (h1_n == 8'd0 && h2_n == 8'd0)
                        win_n = WIN_DRAW;
                    else if (h2_n == 8'd0)
                        win_n = WIN_P1;
                    else
                        win_n = WIN_P2;
                end
            end
            KO: begin
                if (cnt == KO_FRAMES - 8'd1) begin
                    state_n = OVER;
                    cnt_n   = 8'd0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            OVER: begin
                state_n = OVER;
            end
            default: begin
                state_n = COUNTDOWN;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= COUNTDOWN;
            cnt          <= 8'd0;
            health1      <= MAX_HEALTH;
            health2      <= MAX_HEALTH;
            cd1          <= 6'd0;
            cd2          <= 6'd0;
            prev1        <= 10'd0;
            prev2        <= 10'd0;
            winner       <= WIN_NONE;
            hit1         <= 1'b0;
            hit2         <= 1'b0;
            fight_enable <= 1'b0;
        end else begin
            hit1 <= 1'b0;
            hit2 <= 1'b0;
            if (tick) begin
                state        <= state_n;
                cnt          <= cnt_n;
                health1      <= h1_n;
                health2      <= h2_n;
                cd1          <= cd1_n;
                cd2          <= cd2_n;
                prev1        <= action1;
                prev2        <= action2;
                winner       <= win_n;
                hit1         <= land_on1;
                hit2         <= land_on2;
                fight_enable <= (state_n == FIGHT);
            end
        end
    end

endmodule
